// File: rtl/clk_div_sched.sv
// Run-time controller for a power-of-two clock divider (/2, /4, /8, /16) with glitch-free ratio and run/stop changes.
// Latency: outputs decode registered state; a ratio change lands MAX_old - cnt_at_accept + 1 cycles after accept.
// Backpressure: cfg_ready drops while a pending ratio waits for the current period to finish; requester holds cfg_valid.
module clk_div_sched #(
  parameter logic [1:0] RESET_SEL = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_en,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_sel,
  output logic       cfg_ready,
  output logic       div_out,
  output logic       tick,
  output logic       switch_done,
  output logic [1:0] cur_sel,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt, max_cnt;
  logic [1:0] sel_nxt, pend_sel, pend_nxt;
  logic       sw_nxt;
  logic       at_max, accept;

  // Terminal count of the currently applied ratio.
  always_comb begin
    case (cur_sel)
      2'd0:    max_cnt = 4'd1;
      2'd1:    max_cnt = 4'd3;
      2'd2:    max_cnt = 4'd7;
      default: max_cnt = 4'd15;
    endcase
  end

  assign busy      = (state != IDLE);
  assign at_max    = (cnt == max_cnt);
  assign cfg_ready = (state != DRAIN);
  assign accept    = cfg_valid && cfg_ready;
  // Low half first: bit k of the counter is the divided square wave.
  assign div_out   = busy && cnt[cur_sel];
  assign tick      = busy && at_max;

  // Next-state logic: ratio and run/stop changes only take effect at the period boundary.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = cur_sel;
    pend_nxt  = pend_sel;
    sw_nxt    = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = 4'd0;
        // Nothing is running, so a new ratio can apply straight away.
        if (accept) sel_nxt = cfg_sel;
        if (run_en) state_nxt = RUN;
      end
      RUN: begin
        if (at_max) begin
          cnt_nxt = 4'd0;
          if (accept) begin
            sel_nxt = cfg_sel;
            sw_nxt  = 1'b1;
          end
          if (!run_en) state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
          if (accept) begin
            pend_nxt  = cfg_sel;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (at_max) begin
          cnt_nxt   = 4'd0;
          sel_nxt   = pend_sel;
          sw_nxt    = 1'b1;
          state_nxt = run_en ? RUN : IDLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State register; reset discards any pending ratio.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      cur_sel     <= RESET_SEL;
      pend_sel    <= 2'd0;
      switch_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cur_sel     <= sel_nxt;
      pend_sel    <= pend_nxt;
      switch_done <= sw_nxt;
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed table, corner-case sequences, randomized run against a period-level model.
// Latency: compares every cycle, 1 ns after the rising edge.
// Backpressure: the model honours cfg_ready when deciding whether a cfg offer is accepted.
module tb_clk_div_sched;

  localparam logic [1:0] RSEL = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       run_en, cfg_valid;
  logic [1:0] cfg_sel;
  logic       cfg_ready, div_out, tick, switch_done, busy;
  logic [1:0] cur_sel;

  clk_div_sched #(.RESET_SEL(RSEL)) dut (
    .clk(clk), .rst(rst), .run_en(run_en), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
    .cfg_ready(cfg_ready), .div_out(div_out), .tick(tick), .switch_done(switch_done),
    .cur_sel(cur_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int sw_seen  = 0;

  // Reference model: position inside the current output period plus an optional pending ratio.
  bit         m_run, m_pv, m_sw;
  int         m_pos;
  logic [1:0] m_sel, m_pend;

  function automatic void m_reset();
    m_run = 0; m_pv = 0; m_sw = 0; m_pos = 0; m_sel = RSEL; m_pend = 2'd0;
  endfunction

  function automatic logic [6:0] m_vec();
    int   len = 2 << m_sel;
    logic act = m_run || m_pv;
    logic d   = act && (m_pos >= len / 2);
    logic t   = act && (m_pos == len - 1);
    return {d, t, logic'(m_sw), m_sel, act, logic'(!m_pv)};
  endfunction

  function automatic void m_advance(logic r, logic v, logic [1:0] s);
    int len    = 2 << m_sel;
    bit active = m_run || m_pv;
    bit wrap   = active && (m_pos == len - 1);
    bit acc    = v && !m_pv;
    m_sw = 0;
    if (!active) begin
      if (acc) m_sel = s;
      m_run = r;
      m_pos = 0;
    end else if (wrap) begin
      m_pos = 0;
      if (m_pv) begin
        m_sel = m_pend; m_pv = 0; m_sw = 1;
      end else if (acc) begin
        m_sel = s; m_sw = 1;
      end
      m_run = r;
    end else begin
      m_pos++;
      if (acc) begin
        m_pend = s; m_pv = 1;
      end
    end
  endfunction

  function automatic logic [6:0] dut_vec();
    return {div_out, tick, switch_done, cur_sel, busy, cfg_ready};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {div,tick,sw,sel,busy,rdy}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r, input logic v, input logic [1:0] s, input string name);
    run_en = r; cfg_valid = v; cfg_sel = s;
    m_advance(r, v, s);
    @(posedge clk); #1;
    if (switch_done) sw_seen++;
    check(name, dut_vec(), m_vec());
  endtask

  // Async reset assertion away from the clock edge, checked before any edge arrives.
  task automatic async_reset(input string name);
    rst = 1'b0;
    #2;
    m_reset();
    check(name, dut_vec(), {3'b000, RSEL, 2'b01});
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [1:0] s;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic r, logic v, logic [1:0] s, logic [6:0] exp);
    vec_t e;
    e.r = r; e.v = v; e.s = s; e.exp = exp;
    tbl.push_back(e);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, hi, pat;

    // Expected vectors {div,tick,sw,sel[1:0],busy,rdy} after each edge, starting at reset release.
    add(1, 0, 0, 7'b000_00_11);
    add(1, 0, 0, 7'b110_00_11);
    add(1, 0, 0, 7'b000_00_11);
    add(1, 0, 0, 7'b110_00_11);
    add(1, 0, 0, 7'b000_00_11);
    add(1, 1, 3, 7'b110_00_10);   // accepted at cnt=0: DRAIN, ready drops
    add(1, 0, 0, 7'b001_11_11);   // two cycles after accept: switch_done, /16
    for (int i = 1; i <= 7; i++) add(1, 0, 0, 7'b000_11_11);
    for (int i = 8; i <= 14; i++) add(1, 0, 0, 7'b100_11_11);
    add(1, 0, 0, 7'b110_11_11);
    add(1, 0, 0, 7'b000_11_11);

    rst = 1'b0; run_en = 1'b0; cfg_valid = 1'b0; cfg_sel = 2'd0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), {3'b000, RSEL, 2'b01});
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, $sformatf("tbl_model%0d", i));
      check($sformatf("tbl%0d", i), dut_vec(), tbl[i].exp);
    end

    // /16 -> /4 requested at cnt=5: old period completes, then 2 low / 2 high.
    for (int i = 0; i < 40 && m_pos != 5; i++) step(1, 0, 0, "to_cnt5");
    step(1, 1, 1, "req_01");
    lat = 1;
    while (!switch_done && lat < 40) begin
      step(1, 0, 0, "drain_16");
      lat++;
    end
    check_int("lat_11_to_01", lat, 11);
    pat = {31'd0, div_out};
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, "period4");
      pat = (pat << 1) | int'(div_out);
    end
    check_int("period4_shape", pat, 8'b0011_0011);

    // Second cfg held through DRAIN is ignored until ready returns; one switch_done per accept.
    step(1, 0, 0, "align");
    sw_seen = 0;
    step(1, 1, 2, "req_10");
    for (int i = 0; i < 20 && !cfg_ready; i++) step(1, 1, 0, "held_cfg");
    step(1, 1, 0, "accept_00");
    for (int i = 0; i < 20 && !(m_sw && m_sel == 2'd0); i++) step(1, 0, 0, "drain_8");
    check_int("held_sw_count", sw_seen, 2);
    check_int("held_final_sel", int'(cur_sel), 0);

    // Stop requested at /8 with cnt=3: high half completes, then IDLE.
    step(1, 1, 2, "req_div8");
    for (int i = 0; i < 20 && !(m_sw && m_sel == 2'd2); i++) step(1, 0, 0, "to_div8");
    for (int i = 0; i < 20 && m_pos != 3; i++) step(1, 0, 0, "to_cnt3");
    lat = 0; hi = 0;
    while (busy && lat < 20) begin
      step(0, 0, 0, "stop_div8");
      lat++;
      if (div_out) hi++;
    end
    check_int("stop_cycles", lat, 5);
    check_int("stop_high_half", hi, 4);

    // run_en glitch low mid-period must not stop the divider.
    step(1, 0, 0, "restart");
    step(1, 0, 0, "cnt1");
    step(0, 0, 0, "glitch_low");
    step(1, 0, 0, "glitch_high");
    for (int i = 0; i < 6; i++) step(1, 0, 0, "post_glitch");
    check_int("glitch_busy", int'(busy), 1);

    // Reset during DRAIN at /16, cnt=10, pending /2.
    step(1, 1, 3, "req_div16");
    for (int i = 0; i < 20 && !(m_sw && m_sel == 2'd3); i++) step(1, 0, 0, "to_div16");
    for (int i = 0; i < 20 && m_pos != 9; i++) step(1, 0, 0, "to_cnt9");
    step(1, 1, 0, "pend_00");
    check_int("pend_state_ready", int'(cfg_ready), 0);
    async_reset("reset_mid_drain");
    sw_seen = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, "post_rst_idle");
    for (int i = 0; i < 12; i++) step(1, 0, 0, "post_rst_run");
    check_int("post_rst_no_switch", sw_seen, 0);

    // Randomized traffic, including occasional asynchronous resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rand_reset");
      end else begin
        step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 4) == 0),
             2'($urandom_range(0, 3)), "random");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
